// File: rtl/serial_pattern_scan_pkg.sv
// rtl/serial_pattern_scan_pkg.sv - shared types and defaults for the serial pattern scanner
package serial_pattern_scan_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } scan_state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
    localparam int         DEFAULT_LEN     = 4;

endpackage

// File: rtl/serial_pattern_scan_ctrl_match.sv
// rtl/serial_pattern_scan_ctrl_match.sv - serial pattern matcher with length-masked compare
module pattern_match_core #(
    parameter int PAT_W = 4,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             clear,
    output logic             hit
);

    logic [PAT_W-1:0] history_q, history_d;
    logic [LEN_W-1:0] vcnt_q, vcnt_d;
    logic             hit_q, hit_d;
    logic             eq;

    // Shift the new bit into history and compare the low len bits against the pattern.
    always_comb begin
        history_d = history_q;
        vcnt_d    = vcnt_q;
        hit_d     = 1'b0;
        eq        = 1'b1;
        if (clear) begin
            history_d = '0;
            vcnt_d    = '0;
        end else if (bit_valid) begin
            history_d = {history_q[PAT_W-2:0], bit_in};
            if (vcnt_q != LEN_W'(PAT_W)) begin
                vcnt_d = vcnt_q + LEN_W'(1);
            end
            for (int i = 0; i < PAT_W; i++) begin
                if ((i < int'(len)) && (history_d[i] != pattern[i])) begin
                    eq = 1'b0;
                end
            end
            hit_d = (len != '0) && (vcnt_d >= len) && eq;
        end
    end

    // History, valid-bit count and registered hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_q <= '0;
            vcnt_q    <= '0;
            hit_q     <= 1'b0;
        end else begin
            history_q <= history_d;
            vcnt_q    <= vcnt_d;
            hit_q     <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/serial_pattern_scan_ctrl.sv
// rtl/serial_pattern_scan_ctrl.sv - word serialiser, hit counter and threshold alarm
module serial_pattern_scan_ctrl
    import serial_pattern_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [PAT_W-1:0]     cfg_pattern,
    input  logic [$clog2(PAT_W):0] cfg_len,
    input  logic [CNT_W-1:0]     thresh,
    input  logic                 stat_clr,
    input  logic                 in_valid,
    input  logic [WORD_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 hit,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 alarm
);

    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int IDX_W = $clog2(WORD_W);

    scan_state_t       state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              alarm_q, alarm_d;
    logic              accept, cfg_ok, core_hit;

    assign in_ready = (state_q == IDLE) || (idx_q == '0);
    assign busy     = (state_q == SHIFT);
    assign accept   = in_valid && in_ready;
    // A config write racing a word handshake is dropped so the word is never
    // matched against a half-applied pattern.
    assign cfg_ok   = cfg_we && (state_q == IDLE) && !accept;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state logic for the serialiser FSM, configuration and statistics.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        alarm_d   = alarm_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    idx_d   = IDX_W'(WORD_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                idx_d   = idx_q - IDX_W'(1);
                if (idx_q == '0) begin
                    if (in_valid) begin
                        shreg_d = in_data;
                        idx_d   = IDX_W'(WORD_W - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cfg_ok) begin
            pattern_d = cfg_pattern;
            len_d     = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
        end
        if (stat_clr || cfg_ok) begin
            cnt_d   = '0;
            alarm_d = 1'b0;
        end else if (core_hit) begin
            cnt_d = cnt_inc;
            if ((thresh != '0) && (cnt_inc >= thresh)) begin
                alarm_d = 1'b1;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            pattern_q <= PAT_W'(DEFAULT_PATTERN);
            len_q     <= LEN_W'(DEFAULT_LEN);
            cnt_q     <= '0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            alarm_q   <= alarm_d;
        end
    end

    pattern_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (busy),
        .bit_in    (shreg_q[WORD_W-1]),
        .pattern   (pattern_q),
        .len       (len_q),
        .clear     (cfg_ok),
        .hit       (core_hit)
    );

    assign hit       = core_hit;
    assign hit_count = cnt_q;
    assign alarm     = alarm_q;

endmodule
